// File: rtl/piece_pkg.sv
// Shared types and constants for the next-piece queue.
// Pieces are 3-bit codes; 3'd7 marks an empty slot.
package piece_pkg;

  typedef logic [2:0] piece_t;

  localparam int     PIECE_BITS  = 3;
  localparam int     BAG_SIZE    = 7;
  localparam int     QUEUE_DEPTH = 14;
  localparam piece_t PIECE_NONE  = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    LOAD
  } pq_state_t;

  function automatic logic [3:0] qidx(
    input logic [3:0] base,
    input logic [3:0] off
  );
    logic [4:0] s;
    s = {1'b0, base} + {1'b0, off};
    if (s >= 5'(QUEUE_DEPTH))
      s = s - 5'(QUEUE_DEPTH);
    return s[3:0];
  endfunction

endpackage

// File: rtl/piece_fifo.sv
// 14x3 circular piece buffer: 7-wide bag write, single pop,
// in-place head overwrite for hold swaps, and preview taps.
import piece_pkg::*;

module piece_fifo #(
  parameter int PREVIEW = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [20:0]             bag,
  input  logic                    pop,
  input  logic                    swap,
  input  logic [2:0]              swap_piece,
  output logic [2:0]              head,
  output logic                    valid,
  output logic [3:0]              count,
  output logic [3*PREVIEW-1:0]    preview
);

  piece_t     mem [QUEUE_DEPTH];
  logic [3:0] rd;
  logic [3:0] wr;

  always_ff @(posedge clk) begin
    if (!reset && load)
      for (int k = 0; k < BAG_SIZE; k++)
        mem[qidx(wr, 4'(k))] <= bag[PIECE_BITS*k +: PIECE_BITS];
    if (!reset && swap)
      mem[rd] <= swap_piece;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (load)
        wr <= qidx(wr, 4'(BAG_SIZE));
      if (pop)
        rd <= qidx(rd, 4'd1);
      count <= count
             + (load ? 4'(BAG_SIZE) : 4'd0)
             - (pop ? 4'd1 : 4'd0);
    end
  end

  assign valid = (count != 4'd0);
  assign head  = valid ? mem[rd] : PIECE_NONE;

  always_comb begin
    preview = '0;
    for (int j = 0; j < PREVIEW; j++)
      preview[PIECE_BITS*j +: PIECE_BITS] =
        (4'(j + 1) < count) ? mem[qidx(rd, 4'(j + 1))]
                            : PIECE_NONE;
  end

endmodule

// File: rtl/piece_queue.sv
// Next-piece queue: bag refill FSM, ready edge detect, hold slot.
// Hold slot is built only when PIECE_QUEUE_HOLD_EN is defined.
import piece_pkg::*;

module piece_queue #(
  parameter int PREVIEW = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [20:0]          bag,
  input  logic                 ready,
  output logic                 newbag,
  input  logic                 pop,
  input  logic                 hold,
  output logic [2:0]           piece,
  output logic                 piece_valid,
  output logic [3*PREVIEW-1:0] preview,
  output logic [2:0]           hold_piece,
  output logic                 hold_valid
);

  pq_state_t   state;
  logic        ready_q;
  logic [20:0] bag_q;
  logic [3:0]  count;
  logic        load;
  logic        do_pop;
  logic        fifo_pop;
  logic        swap;
  logic [2:0]  swap_piece;

  assign load   = (state == LOAD);
  assign do_pop = pop & piece_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      newbag  <= 1'b0;
      ready_q <= 1'b0;
      bag_q   <= '0;
    end else begin
      ready_q <= ready;
      newbag  <= 1'b0;
      unique case (state)
        IDLE:
          if (count <= 4'(BAG_SIZE)) begin
            state  <= REQ;
            newbag <= 1'b1;
          end
        REQ:
          state <= WAIT;
        // a ready already high on entry is stale
        WAIT:
          if (ready & ~ready_q) begin
            state <= LOAD;
            bag_q <= bag;
          end
        LOAD:
          state <= IDLE;
        default:
          state <= IDLE;
      endcase
    end
  end

`ifdef PIECE_QUEUE_HOLD_EN
  logic   locked;
  logic   do_hold;
  piece_t hold_q;
  logic   hold_v;

  assign do_hold    = hold & ~pop & piece_valid & ~locked;
  assign fifo_pop   = do_pop | (do_hold & ~hold_v);
  assign swap       = do_hold & hold_v;
  assign swap_piece = hold_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_q <= PIECE_NONE;
      hold_v <= 1'b0;
      locked <= 1'b0;
    end else if (do_pop) begin
      locked <= 1'b0;
    end else if (do_hold) begin
      locked <= 1'b1;
      hold_q <= piece;
      hold_v <= 1'b1;
    end
  end

  assign hold_piece = hold_q;
  assign hold_valid = hold_v;
`else
  logic unused_hold;

  assign unused_hold = hold;
  assign fifo_pop    = do_pop;
  assign swap        = 1'b0;
  assign swap_piece  = PIECE_NONE;
  assign hold_piece  = PIECE_NONE;
  assign hold_valid  = 1'b0;
`endif

  piece_fifo #(
    .PREVIEW(PREVIEW)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .bag       (bag_q),
    .pop       (fifo_pop),
    .swap      (swap),
    .swap_piece(swap_piece),
    .head      (piece),
    .valid     (piece_valid),
    .count     (count),
    .preview   (preview)
  );

endmodule

// File: tb/tb_piece_queue.sv
// Scoreboard bench for piece_queue with a queue-based reference
// model and a bag generator that answers newbag requests.
module tb_piece_queue;

  localparam int P = 3;
`ifdef PIECE_QUEUE_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [20:0]   bag = '0;
  logic          ready = 1'b0;
  logic          newbag;
  logic          pop = 1'b0;
  logic          hold = 1'b0;
  logic [2:0]    piece;
  logic          piece_valid;
  logic [3*P-1:0] preview;
  logic [2:0]    hold_piece;
  logic          hold_valid;

  always #5 clk = ~clk;

  piece_queue #(.PREVIEW(P)) dut (
    .clk        (clk),
    .reset      (reset),
    .bag        (bag),
    .ready      (ready),
    .newbag     (newbag),
    .pop        (pop),
    .hold       (hold),
    .piece      (piece),
    .piece_valid(piece_valid),
    .preview    (preview),
    .hold_piece (hold_piece),
    .hold_valid (hold_valid)
  );

  typedef struct {
    logic [2:0] piece;
    logic       valid;
    logic [2:0] pv [P];
    logic [2:0] hp;
    logic       hv;
    logic       nb;
  } snap_t;

  snap_t expq[$];
  int nchk = 0;
  int nfail = 0;

  // reference model state
  logic [2:0]  mq[$];
  logic [2:0]  mh = 3'd7;
  bit          mhv = 0;
  bit          mlock = 0;
  int          cyc = 0;
  int          check_at = -1;
  int          req_at = -10;
  int          load_at = -1;
  bit          awaiting = 0;
  bit          prev_ready = 0;
  logic [20:0] mbag = '0;

  // generator / stimulus knobs
  int drop_at = -1;
  int raise_at = -1;
  bit fixed_bag = 1;
  bit pol = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d at t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    snap_t s;
    int n;
    logic [2:0] t;
    bit req;
    cyc++;
    req = 0;
    if (reset) begin
      mq.delete();
      mh = 3'd7;
      mhv = 0;
      mlock = 0;
      awaiting = 0;
      load_at = -1;
      check_at = cyc + 1;
      prev_ready = 0;
    end else begin
      n = mq.size();
      if (pop && n > 0) begin
        void'(mq.pop_front());
        mlock = 0;
      end else if (HOLD_EN && hold && n > 0 && !mlock) begin
        if (!mhv) begin
          mh = mq.pop_front();
          mhv = 1;
        end else begin
          t = mq[0];
          mq[0] = mh;
          mh = t;
        end
        mlock = 1;
      end
      if (cyc == load_at) begin
        for (int k = 0; k < 7; k++)
          mq.push_back(mbag[3*k +: 3]);
        check_at = cyc + 1;
      end else if (cyc == check_at) begin
        if (n <= 7) begin
          req = 1;
          req_at = cyc;
          awaiting = 1;
        end else begin
          check_at = cyc + 1;
        end
      end else if (awaiting && cyc >= req_at + 2 &&
                   ready && !prev_ready) begin
        load_at = cyc + 1;
        mbag = bag;
        awaiting = 0;
      end
      prev_ready = ready;
    end
    s.valid = (mq.size() > 0);
    s.piece = s.valid ? mq[0] : 3'd7;
    for (int j = 0; j < P; j++)
      s.pv[j] = (j + 1 < mq.size()) ? mq[j+1] : 3'd7;
    s.hp = mh;
    s.hv = mhv;
    s.nb = req;
    expq.push_back(s);
    if (req) begin
      drop_at = cyc + 1;
      raise_at = cyc + 2 + int'($urandom_range(0, 3));
    end
  endtask

  task automatic step(input bit r, input bit p, input bit h);
    @(posedge clk);
    model_edge();
    #1;
    reset = r;
    pop = p | (pol && load_at == cyc + 1);
    hold = h;
    if (cyc == drop_at)
      ready = 1'b0;
    if (cyc == raise_at) begin
      ready = 1'b1;
      bag = fixed_bag ? 21'h1AC688 : 21'($urandom());
    end
  endtask

  initial begin
    snap_t s;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        s = expq.pop_front();
        chk("piece", 32'(piece), 32'(s.piece));
        chk("piece_valid", 32'(piece_valid), 32'(s.valid));
        for (int j = 0; j < P; j++)
          chk($sformatf("preview[%0d]", j),
              32'(preview[3*j +: 3]), 32'(s.pv[j]));
        chk("hold_piece", 32'(hold_piece), 32'(s.hp));
        chk("hold_valid", 32'(hold_valid), 32'(s.hv));
        chk("newbag", 32'(newbag), 32'(s.nb));
      end
    end
  end

  initial begin
    bit found;
    repeat (3) step(1, 0, 0);
    // two fixed bags fill the queue
    repeat (30) step(0, 0, 0);
    repeat (7) step(0, 1, 0);
    pol = 1;
    repeat (14) step(0, 0, 0);
    pol = 0;
    // hold, locked hold, pop, swap
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 1, 0);
    step(0, 0, 1);
    repeat (3) step(0, 0, 0);
    fixed_bag = 0;
    for (int i = 0; i < 1500; i++)
      step(0, $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 15);
    for (int i = 0; i < 1500; i++)
      step(0, $urandom_range(0, 99) < 85,
           $urandom_range(0, 99) < 20);
    // reset in WAIT, then an early ready edge that must not capture
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (awaiting && cyc >= req_at + 2)
        found = 1;
      else
        step(0, $urandom_range(0, 1), 0);
    end
    nchk++;
    if (!found) begin
      nfail++;
      $display("FAIL wait_state_timeout: got 0 expected 1");
    end
    step(1, 0, 0);
    step(0, 0, 0);
    ready = 1'b0;
    step(0, 0, 0);
    ready = 1'b1;
    bag = 21'($urandom());
    repeat (20) step(0, 0, 0);
    for (int i = 0; i < 300; i++)
      step(0, $urandom_range(0, 99) < 40,
           $urandom_range(0, 99) < 15);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
